toe_cam_arbiter: RTL and testbench
==================================

Name: toe_cam_arbiter

Overview:
- Controller and arbiter in front of the ToeCamWrap session CAM in the TOE.
- Sequences CAM initialisation after reset.
- Shares the single lookup port between two requesters (RX session lookup = client 0, TX session lookup = client 1) and routes in-order responses back using a tag FIFO.
- Shares the single update port between two requesters (insert client = 0, delete client = 1) with round-robin fairness.

Parameters:
- KEY_W, 97, key width; matches CAM K.
- VAL_W, 14, value width; matches CAM V.
- OUT_AW, 2, log2 of the maximum number of outstanding lookups (depth 4).

Ports:
- Clk  in  1  single clock for all logic.
- Rst  in  1  asynchronous, active-low reset; asserted when 0.
- CamInitEnb  out  1  drives CAM InitEnb.
- CamInitDone  in  1  from CAM InitDone.
- CamLkpReqValid  out  1  to CAM LookupReqValid.
- CamLkpReqKey  out  KEY_W  to CAM LookupReqKey.
- CamLkpRspValid  in  1  CAM LookupRespValid.
- CamLkpRspHit  in  1  CAM LookupRespHit.
- CamLkpRspValue  in  VAL_W  CAM LookupRespValue.
- CamUpdReady  in  1  CAM UpdateReady.
- CamUpdValid  out  1  to CAM UpdateValid.
- CamUpdOp  out  1  0 = insert, 1 = delete.
- CamUpdKey  out  KEY_W  update key.
- CamUpdValue  out  VAL_W  update value; CAM UpdateStatic is tied 0 outside this block.
- LkpReqValid  in  2  per-client lookup request.
- LkpReqReady  out  2  per-client accept.
- LkpReqKey  in  2*KEY_W  client 0 key in bits [KEY_W-1:0].
- LkpRspValid  out  2  per-client response strobe.
- LkpRspHit  out  1  shared hit flag.
- LkpRspValue  out  VAL_W  shared response value.
- UpdReqValid  in  2  client 0 = insert, client 1 = delete.
- UpdReqReady  out  2  per-client accept.
- UpdReqKey  in  2*KEY_W  packed like LkpReqKey.
- UpdReqValue  in  VAL_W  used by client 0 only.
- Ready  out  1  initialisation complete.
- ErrOrphan  out  1  sticky: a response arrived with no outstanding tag.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; tag FIFO empty; round-robin pointers select client 0.
- FSM states and transitions:
  - IDLE: always goes to INIT on the next cycle.
  - INIT: CamInitEnb = 1. Goes to RUN on the first cycle CamInitDone = 1; CamInitEnb falls in that same transition.
  - RUN: Ready = 1. Terminal state; leaves only via reset.
- Outside RUN, LkpReqReady and UpdReqReady are 0.
- Lookup arbitration (RUN only):
  - Eligible when the tag FIFO is not full (count < 2^OUT_AW).
  - If one client is valid, it is granted.
  - If both are valid, the round-robin pointer picks; the pointer toggles after every two-way grant.
  - LkpReqReady[grant] = 1 combinationally in the same cycle; at most one ready per cycle.
  - On handshake, next cycle: CamLkpReqValid = 1 for exactly one cycle, key registered, and the client id is pushed into the tag FIFO.
  - Issue rate is at most one lookup per cycle.
- Lookup responses:
  - On CamLkpRspValid, pop the FIFO head. Next cycle: LkpRspValid[head] = 1 for one cycle, with Hit/Value registered.
  - Latency is 1 cycle from the CAM response to the client.
  - Push and pop in the same cycle leave the count unchanged. A full FIFO with a simultaneous pop does not admit a new request that cycle; readiness uses the registered count.
  - CamLkpRspValid with an empty FIFO: the response is dropped, ErrOrphan is set and held until reset, and no LkpRspValid is raised.
- Update arbitration (RUN only):
  - Eligible when no update is pending in the output register.
  - Client selection is round-robin, same rule as lookup, with an independent pointer.
  - On handshake, register Op = client id, Key, and Value (0 for deletes); raise CamUpdValid.
  - CamUpdValid holds with stable fields until CamUpdReady = 1; the transfer completes on that edge.
  - A new grant is allowed in the completion cycle, giving back-to-back throughput when CamUpdReady is held high.
- Reset mid-operation:
  - All state clears asynchronously; outstanding tags are discarded.
  - Post-reset CAM responses raise ErrOrphan; this is expected, and the top level holds the CAM in reset together with this block.
- Widths: the FIFO count is OUT_AW+1 bits; the FIFO read and write pointers wrap modulo 2^OUT_AW.

Test Plan:
- Reset release, CamInitDone rises 20 cycles later -> CamInitEnb = 1 from cycle 1 through cycle 20, Ready = 1 from cycle 21, and no ready asserted before Ready.
- Both lookup clients hold valid for 4 grants, CAM response latency 3 -> grants go 0,1,0,1; LkpRspValid pulses go 0,1,0,1, each 1 cycle after its CAM response, with values matching.
- Client 0 issues 5 lookups while CAM responses are withheld -> 4 accepted, LkpReqReady[0] = 0 on the 5th; one response is released -> the 5th is accepted the cycle after the count drops.
- Both update clients valid, CamUpdReady low for 3 cycles then high -> CamUpdValid holds Op = 0 with a stable key for 3 cycles, completes, then Op = 1 is issued on the next cycle.
- CamLkpRspValid with no outstanding lookups -> ErrOrphan = 1, no LkpRspValid; ErrOrphan stays 1 until Rst = 0.
- Rst driven low for 1 cycle with 2 lookups and 1 update pending -> all outputs 0 asynchronously, FSM returns to IDLE then INIT, and the FIFO count is 0.

Source files
------------

// File: rtl/toe_cam_arbiter_if.sv
// Bundle of all signals between toe_cam_arbiter, the session CAM and its clients.
//   CAM side   : init enable/done, lookup request/response, update request/ready.
//   Client side: two lookup requesters (0 = RX, 1 = TX) with a shared response bus,
//                two update requesters (0 = insert, 1 = delete), ready and orphan error.
// Modport master is the arbiter view; slave is the CAM plus client view.
interface toe_cam_arbiter_if #(
    parameter int unsigned KEY_W = 97,
    parameter int unsigned VAL_W = 14
);
    logic               cam_init_enb;
    logic               cam_init_done;
    logic               cam_lkp_req_valid;
    logic [KEY_W-1:0]   cam_lkp_req_key;
    logic               cam_lkp_rsp_valid;
    logic               cam_lkp_rsp_hit;
    logic [VAL_W-1:0]   cam_lkp_rsp_value;
    logic               cam_upd_ready;
    logic               cam_upd_valid;
    logic               cam_upd_op;
    logic [KEY_W-1:0]   cam_upd_key;
    logic [VAL_W-1:0]   cam_upd_value;
    logic [1:0]         lkp_req_valid;
    logic [1:0]         lkp_req_ready;
    logic [2*KEY_W-1:0] lkp_req_key;
    logic [1:0]         lkp_rsp_valid;
    logic               lkp_rsp_hit;
    logic [VAL_W-1:0]   lkp_rsp_value;
    logic [1:0]         upd_req_valid;
    logic [1:0]         upd_req_ready;
    logic [2*KEY_W-1:0] upd_req_key;
    logic [VAL_W-1:0]   upd_req_value;
    logic               ready;
    logic               err_orphan;

    modport master (
        output cam_init_enb, cam_lkp_req_valid, cam_lkp_req_key, cam_upd_valid, cam_upd_op,
               cam_upd_key, cam_upd_value, lkp_req_ready, lkp_rsp_valid, lkp_rsp_hit,
               lkp_rsp_value, upd_req_ready, ready, err_orphan,
        input  cam_init_done, cam_lkp_rsp_valid, cam_lkp_rsp_hit, cam_lkp_rsp_value,
               cam_upd_ready, lkp_req_valid, lkp_req_key, upd_req_valid, upd_req_key,
               upd_req_value
    );

    modport slave (
        input  cam_init_enb, cam_lkp_req_valid, cam_lkp_req_key, cam_upd_valid, cam_upd_op,
               cam_upd_key, cam_upd_value, lkp_req_ready, lkp_rsp_valid, lkp_rsp_hit,
               lkp_rsp_value, upd_req_ready, ready, err_orphan,
        output cam_init_done, cam_lkp_rsp_valid, cam_lkp_rsp_hit, cam_lkp_rsp_value,
               cam_upd_ready, lkp_req_valid, lkp_req_key, upd_req_valid, upd_req_key,
               upd_req_value
    );
endinterface

// File: rtl/toe_cam_arbiter.sv
// Controller/arbiter in front of the TOE session CAM.
//   clk, rst_n : clock, asynchronous active-low reset.
//   bus        : toe_cam_arbiter_if master view (CAM ports + lookup/update clients).
// Sequences CAM init after reset, shares the lookup port between two clients with an
// in-order tag FIFO routing responses back, and shares the update port round-robin.
module toe_cam_arbiter #(
    parameter int unsigned KEY_W  = 97,
    parameter int unsigned VAL_W  = 14,
    parameter int unsigned OUT_AW = 2
) (
    input logic              clk,
    input logic              rst_n,
    toe_cam_arbiter_if.master bus
);
    localparam int unsigned Depth = 2 ** OUT_AW;
    localparam logic [OUT_AW:0]   CntOne = 1;
    localparam logic [OUT_AW-1:0] PtrOne = 1;

    typedef enum logic [1:0] {StIdle, StInit, StRun} state_e;

    state_e state_q, state_d;
    logic   run, init_enb;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= StIdle;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        run      = 1'b0;
        init_enb = 1'b0;
        case (state_q)
            StIdle: state_d = StInit;
            StInit: begin
                init_enb = 1'b1;
                if (bus.cam_init_done) state_d = StRun;
            end
            StRun:   run = 1'b1;
            default: state_d = StIdle;
        endcase
    end

    // ---------------- lookup arbitration and tag FIFO ----------------
    logic [Depth-1:0]  tag_q;
    logic [OUT_AW-1:0] wptr_q, rptr_q;
    logic [OUT_AW:0]   cnt_q;
    logic              lkp_rr_q, lkp_gnt, lkp_hs, pop, orphan;
    logic [1:0]        lkp_ready;
    logic              creq_valid_q;
    logic [KEY_W-1:0]  creq_key_q;
    logic [1:0]        rsp_valid_q;
    logic              rsp_hit_q, err_q;
    logic [VAL_W-1:0]  rsp_value_q;

    always_comb begin
        lkp_ready = 2'b00;
        lkp_hs    = 1'b0;
        case (bus.lkp_req_valid)
            2'b10:   lkp_gnt = 1'b1;
            2'b11:   lkp_gnt = lkp_rr_q;
            default: lkp_gnt = 1'b0;
        endcase
        // count MSB set means the FIFO holds exactly Depth tags
        if (run && !cnt_q[OUT_AW] && bus.lkp_req_valid[lkp_gnt]) begin
            lkp_ready[lkp_gnt] = 1'b1;
            lkp_hs             = 1'b1;
        end
    end

    assign pop    = bus.cam_lkp_rsp_valid && (cnt_q != '0);
    assign orphan = bus.cam_lkp_rsp_valid && (cnt_q == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_q        <= '0;
            wptr_q       <= '0;
            rptr_q       <= '0;
            cnt_q        <= '0;
            lkp_rr_q     <= 1'b0;
            creq_valid_q <= 1'b0;
            creq_key_q   <= '0;
            rsp_valid_q  <= 2'b00;
            rsp_hit_q    <= 1'b0;
            rsp_value_q  <= '0;
            err_q        <= 1'b0;
        end else begin
            creq_valid_q <= lkp_hs;
            if (lkp_hs) begin
                tag_q[wptr_q] <= lkp_gnt;
                wptr_q        <= wptr_q + PtrOne;
                creq_key_q    <= lkp_gnt ? bus.lkp_req_key[2*KEY_W-1:KEY_W]
                                         : bus.lkp_req_key[KEY_W-1:0];
                if (&bus.lkp_req_valid) lkp_rr_q <= ~lkp_rr_q;
            end
            if (pop) begin
                rptr_q      <= rptr_q + PtrOne;
                rsp_valid_q <= tag_q[rptr_q] ? 2'b10 : 2'b01;
                rsp_hit_q   <= bus.cam_lkp_rsp_hit;
                rsp_value_q <= bus.cam_lkp_rsp_value;
            end else begin
                rsp_valid_q <= 2'b00;
            end
            case ({lkp_hs, pop})
                2'b10:   cnt_q <= cnt_q + CntOne;
                2'b01:   cnt_q <= cnt_q - CntOne;
                default: cnt_q <= cnt_q;
            endcase
            if (orphan) err_q <= 1'b1;
        end
    end

    // ---------------- update arbitration ----------------
    logic             upd_rr_q, upd_gnt, upd_hs;
    logic [1:0]       upd_ready;
    logic             uvalid_q, uop_q;
    logic [KEY_W-1:0] ukey_q;
    logic [VAL_W-1:0] uval_q;

    always_comb begin
        upd_ready = 2'b00;
        upd_hs    = 1'b0;
        case (bus.upd_req_valid)
            2'b10:   upd_gnt = 1'b1;
            2'b11:   upd_gnt = upd_rr_q;
            default: upd_gnt = 1'b0;
        endcase
        // the output register frees up in the same cycle the CAM takes its contents
        if (run && (!uvalid_q || bus.cam_upd_ready) && bus.upd_req_valid[upd_gnt]) begin
            upd_ready[upd_gnt] = 1'b1;
            upd_hs             = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            upd_rr_q <= 1'b0;
            uvalid_q <= 1'b0;
            uop_q    <= 1'b0;
            ukey_q   <= '0;
            uval_q   <= '0;
        end else if (upd_hs) begin
            uvalid_q <= 1'b1;
            uop_q    <= upd_gnt;
            ukey_q   <= upd_gnt ? bus.upd_req_key[2*KEY_W-1:KEY_W] : bus.upd_req_key[KEY_W-1:0];
            uval_q   <= upd_gnt ? '0 : bus.upd_req_value;
            if (&bus.upd_req_valid) upd_rr_q <= ~upd_rr_q;
        end else if (bus.cam_upd_ready) begin
            uvalid_q <= 1'b0;
        end
    end

    assign bus.cam_init_enb      = init_enb;
    assign bus.ready             = run;
    assign bus.cam_lkp_req_valid = creq_valid_q;
    assign bus.cam_lkp_req_key   = creq_key_q;
    assign bus.lkp_req_ready     = lkp_ready;
    assign bus.lkp_rsp_valid     = rsp_valid_q;
    assign bus.lkp_rsp_hit       = rsp_hit_q;
    assign bus.lkp_rsp_value     = rsp_value_q;
    assign bus.err_orphan        = err_q;
    assign bus.upd_req_ready     = upd_ready;
    assign bus.cam_upd_valid     = uvalid_q;
    assign bus.cam_upd_op        = uop_q;
    assign bus.cam_upd_key       = ukey_q;
    assign bus.cam_upd_value     = uval_q;
endmodule

// File: tb/tb_toe_cam_arbiter.sv
// Self-checking bench for toe_cam_arbiter: directed steps plus randomized traffic,
// compared each cycle against a queue-based behavioural model.
module tb_toe_cam_arbiter;
    localparam int unsigned KW = 97;
    localparam int unsigned VW = 14;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    toe_cam_arbiter_if #(.KEY_W(KW), .VAL_W(VW)) bus ();

    toe_cam_arbiter #(.KEY_W(KW), .VAL_W(VW), .OUT_AW(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    // behavioural model state
    int             mstate;    // 0 idle, 1 init, 2 run
    bit             q[$];      // outstanding lookup owners, oldest first
    bit             lrr, urr;
    int             seen;      // requests the CAM has seen but not answered
    logic           e_creq_v;
    logic [KW-1:0]  e_creq_key;
    logic [1:0]     e_rsp_v;
    logic           e_hit;
    logic [VW-1:0]  e_val;
    logic           e_uv, e_uop;
    logic [KW-1:0]  e_ukey;
    logic [VW-1:0]  e_uval;
    logic           e_err;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [1:0] v, input bit rr);
        if (v == 2'b11) return int'(rr);
        if (v[0]) return 0;
        if (v[1]) return 1;
        return -1;
    endfunction

    function automatic logic [KW-1:0] rkey();
        logic [127:0] t;
        t = {$urandom, $urandom, $urandom, $urandom};
        return t[KW-1:0];
    endfunction

    task automatic model_reset();
        mstate = 0; q.delete(); lrr = 0; urr = 0; seen = 0;
        e_creq_v = 0; e_creq_key = '0; e_rsp_v = 2'b00; e_hit = 0; e_val = '0;
        e_uv = 0; e_uop = 0; e_ukey = '0; e_uval = '0; e_err = 0;
    endtask

    task automatic zero_inputs();
        bus.cam_init_done = 0; bus.cam_lkp_rsp_valid = 0; bus.cam_lkp_rsp_hit = 0;
        bus.cam_lkp_rsp_value = '0; bus.cam_upd_ready = 0; bus.lkp_req_valid = 2'b00;
        bus.lkp_req_key = '0; bus.upd_req_valid = 2'b00; bus.upd_req_key = '0;
        bus.upd_req_value = '0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, ".outs"}, {bus.cam_init_enb, bus.ready, bus.cam_lkp_req_valid,
            bus.lkp_req_ready, bus.lkp_rsp_valid, bus.upd_req_ready, bus.cam_upd_valid,
            bus.cam_upd_op, bus.err_orphan, bus.lkp_rsp_hit}, '0);
        chk({tag, ".keys"}, {bus.cam_lkp_req_key, bus.cam_upd_key[30:0]}, '0);
        chk({tag, ".vals"}, {bus.lkp_rsp_value, bus.cam_upd_value}, '0);
    endtask

    // Random data on all inputs; probabilities in percent. Keeps init_done as is.
    task automatic rand_inputs(input int pl, input int pu, input int pr, input int pur);
        bus.lkp_req_valid     = {$urandom_range(99) < pl, $urandom_range(99) < pl};
        bus.lkp_req_key       = {rkey(), rkey()};
        bus.upd_req_valid     = {$urandom_range(99) < pu, $urandom_range(99) < pu};
        bus.upd_req_key       = {rkey(), rkey()};
        bus.upd_req_value     = VW'($urandom);
        bus.cam_lkp_rsp_valid = (seen > 0) && ($urandom_range(99) < pr);
        bus.cam_lkp_rsp_hit   = 1'($urandom);
        bus.cam_lkp_rsp_value = VW'($urandom);
        bus.cam_upd_ready     = $urandom_range(99) < pur;
    endtask

    // Called at a negedge with this cycle's inputs applied; checks, advances model,
    // returns at the next negedge.
    task automatic cycle();
        int lk, uk;
        logic [1:0] e_lrdy, e_urdy;
        bit run;
        #1;
        run = (mstate == 2);
        lk = (run && q.size() < 4) ? pick(bus.lkp_req_valid, lrr) : -1;
        uk = (run && (!e_uv || bus.cam_upd_ready)) ? pick(bus.upd_req_valid, urr) : -1;
        e_lrdy = (lk >= 0) ? 2'(1 << lk) : 2'b00;
        e_urdy = (uk >= 0) ? 2'(1 << uk) : 2'b00;

        chk("init_enb", bus.cam_init_enb, mstate == 1);
        chk("ready", bus.ready, run);
        chk("lkp_req_ready", bus.lkp_req_ready, e_lrdy);
        chk("upd_req_ready", bus.upd_req_ready, e_urdy);
        chk("cam_lkp_req_valid", bus.cam_lkp_req_valid, e_creq_v);
        if (e_creq_v) chk("cam_lkp_req_key", bus.cam_lkp_req_key, e_creq_key);
        chk("lkp_rsp_valid", bus.lkp_rsp_valid, e_rsp_v);
        if (e_rsp_v != 0) chk("lkp_rsp_data", {bus.lkp_rsp_hit, bus.lkp_rsp_value},
                              {e_hit, e_val});
        chk("cam_upd_valid", bus.cam_upd_valid, e_uv);
        if (e_uv) begin
            chk("cam_upd_op", bus.cam_upd_op, e_uop);
            chk("cam_upd_key", bus.cam_upd_key, e_ukey);
            chk("cam_upd_value", bus.cam_upd_value, e_uval);
        end
        chk("err_orphan", bus.err_orphan, e_err);

        // advance the model across the coming rising edge
        if (e_creq_v) seen++;
        if (bus.cam_lkp_rsp_valid && seen > 0) seen--;
        if (mstate == 0) mstate = 1;
        else if (mstate == 1 && bus.cam_init_done) mstate = 2;

        e_rsp_v = 2'b00;
        if (bus.cam_lkp_rsp_valid) begin
            if (q.size() > 0) begin
                e_rsp_v = q.pop_front() ? 2'b10 : 2'b01;
                e_hit   = bus.cam_lkp_rsp_hit;
                e_val   = bus.cam_lkp_rsp_value;
            end else begin
                e_err = 1;
            end
        end

        e_creq_v = (lk >= 0);
        if (lk >= 0) begin
            q.push_back(lk[0]);
            e_creq_key = bus.lkp_req_key[lk*KW +: KW];
            if (bus.lkp_req_valid == 2'b11) lrr = ~lrr;
        end

        if (uk >= 0) begin
            e_uv   = 1;
            e_uop  = uk[0];
            e_ukey = bus.upd_req_key[uk*KW +: KW];
            e_uval = (uk == 1) ? '0 : bus.upd_req_value;
            if (bus.upd_req_valid == 2'b11) urr = ~urr;
        end else if (bus.cam_upd_ready) begin
            e_uv = 0;
        end
        @(negedge clk);
    endtask

    task automatic async_reset(input string tag);
        #2 rst_n = 1'b0;
        #1 check_all_zero(tag);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        zero_inputs();
        rst_n = 1'b1;
    endtask

    initial begin
        zero_inputs();
        model_reset();
        #3 check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // init sequencing: done rises 20 cycles after release; clients already pushing
        for (int i = 0; i < 22; i++) begin
            rand_inputs(70, 70, 0, 50);
            bus.cam_init_done = (i >= 20);
            cycle();
        end

        // both lookup clients for 4 grants, CAM answers 3 cycles after each request
        for (int i = 0; i < 10; i++) begin
            rand_inputs(0, 0, 0, 0);
            bus.lkp_req_valid     = (i < 4) ? 2'b11 : 2'b00;
            bus.cam_lkp_rsp_valid = (i >= 4 && i < 8);
            cycle();
        end

        // client 0 fills the tag FIFO, then one response frees a slot
        for (int i = 0; i < 9; i++) begin
            rand_inputs(0, 0, 0, 0);
            bus.lkp_req_valid     = 2'b01;
            bus.cam_lkp_rsp_valid = (i == 5);
            cycle();
        end
        for (int i = 0; i < 10; i++) begin
            rand_inputs(0, 0, 100, 0);
            cycle();
        end

        // both update clients, CAM stalls 3 cycles then accepts
        for (int i = 0; i < 8; i++) begin
            rand_inputs(0, 0, 0, 0);
            bus.upd_req_valid = (i < 5) ? 2'b11 : 2'b00;
            bus.cam_upd_ready = (i >= 3);
            cycle();
        end

        // randomized traffic with varying pressure
        for (int i = 0; i < 3000; i++) begin
            rand_inputs(i < 1500 ? 60 : 95, 50, i < 1500 ? 60 : 25, 40);
            cycle();
        end

        // drain, then a response with nothing outstanding
        for (int i = 0; i < 12; i++) begin
            rand_inputs(0, 0, 100, 100);
            cycle();
        end
        rand_inputs(0, 0, 0, 100);
        bus.cam_lkp_rsp_valid = 1'b1;
        cycle();
        for (int i = 0; i < 4; i++) begin
            rand_inputs(30, 30, 100, 50);
            cycle();
        end

        // reset with two lookups and one update in flight
        for (int i = 0; i < 3; i++) begin
            rand_inputs(0, 0, 0, 0);
            bus.lkp_req_valid = (i < 2) ? 2'b11 : 2'b00;
            bus.upd_req_valid = (i == 0) ? 2'b01 : 2'b00;
            cycle();
        end
        async_reset("midop_reset");
        for (int i = 0; i < 5; i++) begin
            rand_inputs(80, 80, 0, 50);
            bus.cam_init_done = (i >= 3);
            cycle();
        end
        for (int i = 0; i < 300; i++) begin
            rand_inputs(80, 60, 50, 50);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
